// File: rtl/multiplexor_n_a_1_sec.sv
// N-channel registered multiplexer with fixed-select or round-robin grant.
// Every input channel and the output stage use a valid/ready handshake.
// The output stage holds one entry and can drain and reload on the same edge.

// Per-channel accept: a channel is ready only when it holds the grant
// and the output register can take new data.
module multiplexor_n_a_1_sec_lane #(
    parameter int SW  = 2,
    parameter int IDX = 0
) (
    input  logic          rst_n,
    input  logic          load_en,
    input  logic          grant_valid,
    input  logic [SW-1:0] grant,
    output logic          in_ready
);
    assign in_ready = rst_n & load_en & grant_valid & (grant == SW'(IDX));
endmodule

module multiplexor_n_a_1_sec #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_chan,
    output logic               out_valid,
    input  logic               out_ready
);
    logic             load_en;
    logic             grant_valid;
    logic [SW-1:0]    grant;
    logic [SW-1:0]    ptr;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;
    int               idx;

    assign load_en = ~out_valid | out_ready;

    // Grant: explicit select (out-of-range select never matches) or a
    // round-robin scan starting at ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        if (!mode) begin
            for (int k = 0; k < N; k++) begin
                if (sel == SW'(k) && in_valid[k]) begin
                    grant_valid = 1'b1;
                    grant       = SW'(k);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                idx = (int'(ptr) + i) % N;
                if (!grant_valid && in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant       = SW'(idx);
                end
            end
        end
    end

    assign xfer       = grant_valid & load_en;
    assign grant_data = in_data[int'(grant)*WIDTH +: WIDTH];

    for (genvar k = 0; k < N; k++) begin : g_lane
        multiplexor_n_a_1_sec_lane #(.SW(SW), .IDX(k)) u_lane (
            .rst_n       (rst_n),
            .load_en     (load_en),
            .grant_valid (grant_valid),
            .grant       (grant),
            .in_ready    (in_ready[k])
        );
    end

    // Output register and round-robin pointer; a transfer wins over a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_chan  <= grant;
            if (mode)
                ptr <= (grant == SW'(N-1)) ? '0 : grant + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_multiplexor_n_a_1_sec.sv
// Directed bench for multiplexor_n_a_1_sec: N=4 instance checked every cycle
// against a behavioural model, plus an N=3 instance for out-of-range select.
module tb_multiplexor_n_a_1_sec;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic        m3_mode;
    logic [1:0]  m3_sel;
    logic [23:0] m3_data = {8'h33, 8'h22, 8'h11};
    logic [2:0]  m3_valid;
    logic [2:0]  m3_ready;
    logic [7:0]  m3_out_data;
    logic [1:0]  m3_out_chan;
    logic        m3_out_valid;
    logic        m3_out_ready;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    // model state for the N=4 instance
    bit       m_valid = 1'b0;
    bit [7:0] m_data  = 8'h0;
    bit [1:0] m_chan  = 2'd0;
    int       m_ptr   = 0;

    always #5 clk = ~clk;

    multiplexor_n_a_1_sec #(.WIDTH(8), .N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
    );

    multiplexor_n_a_1_sec #(.WIDTH(8), .N(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_data(m3_data), .in_valid(m3_valid),
        .in_ready(m3_ready), .mode(m3_mode), .sel(m3_sel), .out_data(m3_out_data),
        .out_chan(m3_out_chan), .out_valid(m3_out_valid), .out_ready(m3_out_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Which channel the rules grant, if any.
    function automatic void grant_of(input int n, input bit md, input int s,
                                     input logic [3:0] v, input int p,
                                     output int g, output bit ok);
        ok = 1'b0;
        g  = 0;
        if (!md) begin
            if (s < n && v[s] === 1'b1) begin ok = 1'b1; g = s; end
        end else begin
            for (int k = 0; k < n; k++) begin
                int c;
                c = (p + k) % n;
                if (!ok && v[c] === 1'b1) begin ok = 1'b1; g = c; end
            end
        end
    endfunction

    // Model update on each edge.
    always @(posedge clk or negedge rst_n) begin
        int g;
        bit ok;
        if (!rst_n) begin
            m_valid <= 1'b0; m_data <= 8'h0; m_chan <= 2'd0; m_ptr <= 0;
        end else begin
            grant_of(4, mode, int'(sel), in_valid, m_ptr, g, ok);
            if (ok && (!m_valid || out_ready)) begin
                m_valid <= 1'b1;
                m_data  <= in_data[g*8 +: 8];
                m_chan  <= 2'(g);
                if (mode) m_ptr <= (g + 1) % 4;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare DUT against model mid-cycle.
    always @(negedge clk) begin
        int g;
        bit ok;
        logic [3:0] eir;
        #2;
        if (!done) begin
            grant_of(4, mode, int'(sel), in_valid, m_ptr, g, ok);
            eir = (rst_n && ok && (!m_valid || out_ready)) ? (4'b0001 << g) : 4'b0000;
            chk("mdl_in_ready", 32'(in_ready), 32'(eir));
            chk("mdl_out_valid", 32'(out_valid), 32'(m_valid));
            chk("mdl_out_data", 32'(out_data), 32'(m_data));
            chk("mdl_out_chan", 32'(out_chan), 32'(m_chan));
        end
    end

    task automatic drive(input bit md, input logic [1:0] s, input logic [3:0] v, input bit rdy);
        @(negedge clk);
        mode = md; sel = s; in_valid = v; out_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
    int rr2_exp[3] = '{3, 0, 3};

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'h0; out_ready = 1'b0;
        m3_mode = 1'b0; m3_sel = 2'd0; m3_valid = 3'b000; m3_out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_chan", 32'(out_chan), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // fixed select
        drive(1'b0, 2'd2, 4'b0100, 1'b1);
        chk("fix_in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("fix_out_data", 32'(out_data), 32'hA5);
        chk("fix_out_chan", 32'(out_chan), 32'd2);
        chk("fix_out_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 2'd1, 4'b0100, 1'b1);
        chk("fix_nogrant_ready", 32'(in_ready), 32'd0);
        tick();
        chk("fix_drop_valid", 32'(out_valid), 32'd0);

        // round-robin wrap
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_chan", 32'(out_chan), 32'(rr_exp[i]));
        end
        drive(1'b1, 2'd0, 4'b1001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_sparse_chan", 32'(out_chan), 32'(rr2_exp[i]));
        end

        // backpressure
        drive(1'b1, 2'd0, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp_out_data", 32'(out_data), 32'h44);
            chk("bp_out_chan", 32'(out_chan), 32'd3);
        end
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        chk("bp_release_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("bp_nobubble_valid", 32'(out_valid), 32'd1);
        chk("bp_nobubble_chan", 32'(out_chan), 32'd0);
        chk("bp_nobubble_data", 32'(out_data), 32'h11);

        // mode switch keeps ptr
        drive(1'b1, 2'd0, 4'b0010, 1'b1);
        tick();
        chk("ms_rr_chan", 32'(out_chan), 32'd1);
        drive(1'b0, 2'd0, 4'b1111, 1'b1);
        tick();
        chk("ms_fix_chan0", 32'(out_chan), 32'd0);
        tick();
        chk("ms_fix_chan1", 32'(out_chan), 32'd0);
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        chk("ms_back_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("ms_back_chan", 32'(out_chan), 32'd2);
        chk("ms_back_data", 32'(out_data), 32'hA5);

        // out-of-range select on N=3
        @(negedge clk);
        m3_mode = 1'b0; m3_sel = 2'd1; m3_valid = 3'b111; m3_out_ready = 1'b1;
        #1;
        chk("n3_in_ready", 32'(m3_ready), 32'b010);
        tick();
        chk("n3_out_valid", 32'(m3_out_valid), 32'd1);
        chk("n3_out_chan", 32'(m3_out_chan), 32'd1);
        chk("n3_out_data", 32'(m3_out_data), 32'h22);
        @(negedge clk);
        m3_sel = 2'd3;
        #1;
        chk("n3_oor_ready", 32'(m3_ready), 32'd0);
        tick();
        chk("n3_oor_empty0", 32'(m3_out_valid), 32'd0);
        tick();
        chk("n3_oor_empty1", 32'(m3_out_valid), 32'd0);
        chk("n3_oor_ready2", 32'(m3_ready), 32'd0);

        // asynchronous reset mid-stream
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_chan", 32'(out_chan), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_chan", 32'(out_chan), 32'd0);
        repeat (4) tick();

        @(negedge clk);
        done = 1'b1;
        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
